// File: rtl/div_seq_pkg.sv
// Shared state encoding and sizing helpers for the sequential restoring divider.
package div_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Iteration counter must be able to hold WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_seq_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and shift the quotient bit into dq.
module div_seq_step
    import div_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_pr,
    input  logic [WIDTH-1:0] i_dq,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_pr_next,
    output logic [WIDTH-1:0] o_dq_next
);

    logic [WIDTH:0] w_t;
    logic [WIDTH:0] w_diff;
    logic           w_ge;

    assign w_t    = {i_pr, i_dq[WIDTH-1]};
    assign w_ge   = (w_t >= {1'b0, i_divisor});
    assign w_diff = w_t - {1'b0, i_divisor};

    // After the restore step the remainder is below the divisor, so WIDTH bits hold it.
    assign o_pr_next = w_ge ? w_diff[WIDTH-1:0] : w_t[WIDTH-1:0];
    assign o_dq_next = {i_dq[WIDTH-2:0], w_ge};

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle unsigned restoring divider: FSM, counter and start/done handshake.
// Optional macro DIV_SEQ_EARLY_TERM_EN skips leading-zero iterations of the dividend.
module div_seq_ctrl
    import div_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output state_t           o_dbg_state
);

    localparam int CW = cnt_width(WIDTH);

    // Handshake: a start is accepted on the rising edge where start & ready are both 1;
    // done pulses for exactly one cycle and results stay valid until the next accept.
    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_dq;
    logic [WIDTH-1:0] r_pr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dbz;

    logic             w_accept;
    logic             w_last_step;
    logic [WIDTH-1:0] w_pr_next;
    logic [WIDTH-1:0] w_dq_next;
    logic [WIDTH-1:0] w_dq_init;
    logic [CW-1:0]    w_count_init;

`ifdef DIV_SEQ_EARLY_TERM_EN
    logic [CW-1:0] w_lead_pos;

    always_comb begin
        w_lead_pos = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (dividend[i]) w_lead_pos = CW'(i);
        end
    end

    // Align the leading one to the MSB so only p+1 iterations remain.
    assign w_dq_init    = dividend << (CW'(WIDTH - 1) - w_lead_pos);
    assign w_count_init = w_lead_pos + CW'(1);
`else
    assign w_dq_init    = dividend;
    assign w_count_init = CW'(WIDTH);
`endif

    assign ready       = (r_state != S_ITER);
    assign busy        = (r_state == S_ITER);
    assign done        = (r_state == S_DONE);
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;
    assign o_dbg_state = r_state;

    assign w_accept    = start & ready;
    assign w_last_step = (r_state == S_ITER) && (r_count == CW'(1));

    div_seq_step #(.WIDTH(WIDTH)) u_step (
        .i_pr      (r_pr),
        .i_dq      (r_dq),
        .i_divisor (r_divisor),
        .o_pr_next (w_pr_next),
        .o_dq_next (w_dq_next)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) w_state_next = (divisor == '0) ? S_DONE : S_ITER;
                else       w_state_next = S_IDLE;
            end
            S_ITER: begin
                if (w_last_step) w_state_next = S_DONE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_divisor   <= '0;
            r_dq        <= '0;
            r_pr        <= '0;
            r_count     <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_divisor <= divisor;
                r_dq      <= w_dq_init;
                r_pr      <= '0;
                r_count   <= w_count_init;
                // Divide by zero finishes on the accept edge itself: no iterations.
                if (divisor == '0) begin
                    r_quotient  <= '1;
                    r_remainder <= dividend;
                    r_dbz       <= 1'b1;
                end else begin
                    r_dbz <= 1'b0;
                end
            end else if (r_state == S_ITER) begin
                r_pr    <= w_pr_next;
                r_dq    <= w_dq_next;
                r_count <= r_count - CW'(1);
                if (w_last_step) begin
                    r_quotient  <= w_dq_next;
                    r_remainder <= w_pr_next;
                end
            end
        end
    end

endmodule
